chip8_memory: RTL and testbench
===============================

# chip8_memory

Main 4 KiB byte-addressable RAM of the CHIP-8 core, shared by instruction fetch, the sprite/draw path and the load/store opcodes. The built-in hexadecimal font is preloaded at address 0x000 at configuration. It has one synchronous read port with a one-cycle acknowledge and one independent synchronous write port.

## Interface
- ADDR_W, 12: address width (4096 locations).
- DATA_W, 8: byte width.
- FONT_BASE, 12'h000: first address of the preloaded font.

- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- read  in  1  read request, sampled each rising edge.
- read_addr  in  ADDR_W  read address, sampled with read.
- read_data  out  DATA_W  registered read data.
- read_ack  out  1  high for exactly the cycle after each sampled read.
- write  in  1  write strobe, sampled each rising edge.
- write_addr  in  ADDR_W  write address.
- write_data  in  DATA_W  byte to store.

## Operation
- Storage is a 4096 x 8 array. At configuration, 0x000–0x04F hold the 80-byte font (16 glyphs x 5 rows, digits 0–F). Standard CHIP-8 values; glyph "0" = F0 90 90 90 F0, "1" = 20 60 20 20 70, ..., "F" = F0 80 F0 80 80. All other bytes are 0x00.
- Write: on a rising edge with write=1, mem[write_addr] <= write_data. The font region is writable, with no protection.
- Read: on a rising edge with read=1, read_data <= mem[read_addr] and read_ack <= 1.
- On an edge with read=0: read_ack <= 0, and read_data holds its previous value.
- Same-edge read and write at the same address is read-before-write: read_data returns the old byte, and the new byte is visible to later reads.
- Read and write at different addresses on the same edge are fully independent.
- Reset: read_ack <= 0 and read_data <= 0x00. Array contents, including any overwritten font bytes, are not modified by reset.
- rst has priority over a same-edge read for the output registers. A same-edge write is still performed.
- Addresses are exactly ADDR_W bits; there is no out-of-range case.

## Timing
- Read latency is 1 cycle. With read=1 at edge N, read_data and read_ack are valid after edge N and remain valid until edge N+1.
- Back-to-back reads (read held high) keep read_ack high continuously, with new data every cycle.
- read_ack is never high in a cycle that follows an edge where read=0 or rst=1.
- Write latency is 1 cycle. A read sampled at the edge after the write returns the new data.
- There is no stall and no busy state. Both ports accept a request every cycle.
- Output reset values: read_data = 0x00, read_ack = 0.

## Structure
- Shared package chip8_pkg holds:
  - CHIP8_ADDR_W = 12 and CHIP8_DATA_W = 8.
  - FONT_BASE.
  - The 80-entry font constant array, also used by the display/opcode logic that computes glyph addresses (FX29: FONT_BASE + 5*digit).
- One sub-module is natural: chip8_font_rom. It is a combinational lookup of a font byte by index 0–79 and is used to initialise the array.
- The array is inferred as block RAM, with a registered read port and a separate write port (simple dual-port).

## Test plan
- Power-up font check: read addr 0x000 -> after one edge read_data=0xF0, read_ack=1. Read 0x004 -> 0xF0. Read 0x005 -> 0x20. Read 0x04F -> 0x80. Read 0x050 -> 0x00.
- Ack pulse: single-cycle read then read=0 -> read_ack high for one cycle, then 0. read_ack stays 0 throughout a burst of write-only cycles.
- Full sweep: write (i mod 255) to every address i = 0..4095, then read each back one at a time. Each read returns i mod 255 with read_ack=1 (e.g. 0x0FF -> 0x00, 0xFFF -> 0x0F).
- Collision: write 0xAA to 0x200 while reading 0x200 on the same edge -> read_data = old byte. The next read returns 0xAA.
- Reset: assert rst alongside read=1 -> read_ack=0 and read_data=0x00 after the edge. A subsequent read shows earlier written data is preserved.
- Streaming: hold read=1 across addresses 0x000–0x004 -> read_ack stays high and read_data follows F0 90 90 90 F0, one byte per cycle.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 constants: bus widths, font placement and the built-in hex font.
package chip8_pkg;

    localparam int unsigned CHIP8_ADDR_W = 12;
    localparam int unsigned CHIP8_DATA_W = 8;
    localparam int unsigned FONT_LEN     = 80;
    localparam logic [CHIP8_ADDR_W-1:0] CHIP8_FONT_BASE = 12'h000;

    // 16 glyphs x 5 rows, digits 0..F.
    localparam logic [7:0] CHIP8_FONT [FONT_LEN] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    // Glyph start address for FX29.
    function automatic logic [CHIP8_ADDR_W-1:0] font_glyph_addr(input logic [3:0] digit);
        return CHIP8_FONT_BASE + CHIP8_ADDR_W'(digit) * CHIP8_ADDR_W'(5);
    endfunction

endpackage

// File: rtl/chip8_memory_font_rom.sv
// Combinational font byte lookup by index 0..79; indices beyond the font read 0x00.
module chip8_font_rom
    import chip8_pkg::*;
(
    input  logic [6:0] index_i,
    output logic [7:0] data_c_o
);

    always_comb begin
        data_c_o = 8'h00;
        if (index_i < 7'(FONT_LEN)) begin
            data_c_o = CHIP8_FONT[index_i];
        end
    end

endmodule

// File: rtl/chip8_memory.sv
// CHIP-8 main RAM: simple dual-port byte array with registered read/ack and font preload.
module chip8_memory
    import chip8_pkg::*;
#(
    parameter int unsigned            ADDR_W    = CHIP8_ADDR_W,
    parameter int unsigned            DATA_W    = CHIP8_DATA_W,
    parameter logic [ADDR_W-1:0]      FONT_BASE = ADDR_W'(CHIP8_FONT_BASE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_data,
    output logic              read_ack,
    input  logic              write,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    // Power-up state is set by configuration; the font comes from the ROM until a
    // font byte is first written, after which the array copy is authoritative.
    logic [DATA_W-1:0]   mem_q [DEPTH] = '{default: '0};
    logic [FONT_LEN-1:0] font_ovr_q    = '0;

    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              read_ack_q;
    logic [ADDR_W-1:0] rd_off, wr_off;
    logic              rd_in_font, wr_in_font;
    logic [7:0]        font_byte;

    assign rd_off     = read_addr - FONT_BASE;
    assign wr_off     = write_addr - FONT_BASE;
    assign rd_in_font = rd_off < ADDR_W'(FONT_LEN);
    assign wr_in_font = wr_off < ADDR_W'(FONT_LEN);

    chip8_font_rom u_font_rom (
        .index_i  (7'(rd_off)),
        .data_c_o (font_byte)
    );

    // Write port: no reset, array and override flags survive rst.
    always_ff @(posedge clk) begin
        if (write) begin
            mem_q[write_addr] <= write_data;
            if (wr_in_font) begin
                font_ovr_q[7'(wr_off)] <= 1'b1;
            end
        end
    end

    // Old contents are sampled here, giving read-before-write on collisions.
    always_comb begin
        read_data_d = mem_q[read_addr];
        if (rd_in_font && !font_ovr_q[7'(rd_off)]) begin
            read_data_d = DATA_W'(font_byte);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q <= '0;
            read_ack_q  <= 1'b0;
        end else begin
            read_ack_q <= read;
            if (read) begin
                read_data_q <= read_data_d;
            end
        end
    end

    assign read_data = read_data_q;
    assign read_ack  = read_ack_q;

endmodule

// File: tb/tb_chip8_memory.sv
// Directed self-checking bench for chip8_memory.
module tb_chip8_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        read;
    logic [11:0] read_addr;
    logic [7:0]  read_data;
    logic        read_ack;
    logic        write;
    logic [11:0] write_addr;
    logic [7:0]  write_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    chip8_memory #(
        .ADDR_W    (12),
        .DATA_W    (8),
        .FONT_BASE (12'h000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .read       (read),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .read_ack   (read_ack),
        .write      (write),
        .write_addr (write_addr),
        .write_data (write_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        read  = 1'b0;
        write = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [7:0] exp, input string tag);
        read      = 1'b1;
        read_addr = a;
        step();
        check({tag, "_data"}, 32'(read_data), 32'(exp));
        check({tag, "_ack"}, 32'(read_ack), 32'd1);
        read = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        write      = 1'b1;
        write_addr = a;
        write_data = d;
        step();
        write = 1'b0;
    endtask

    logic [7:0] stream_exp [5];

    initial begin
        stream_exp = '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0};
        idle();
        read_addr  = '0;
        write_addr = '0;
        write_data = '0;
        rst = 1'b1;
        #1;
        step();
        check("rst_data", 32'(read_data), 32'h00);
        check("rst_ack", 32'(read_ack), 32'd0);
        rst = 1'b0;
        step();
        check("idle_ack", 32'(read_ack), 32'd0);

        // Power-up font contents.
        rd(12'h000, 8'hF0, "font_000");
        rd(12'h004, 8'hF0, "font_004");
        rd(12'h005, 8'h20, "font_005");
        rd(12'h037, 8'hE0, "font_B0");
        rd(12'h04F, 8'h80, "font_04F");
        rd(12'h050, 8'h00, "post_font");

        // Ack is a single-cycle pulse; data holds.
        rd(12'h001, 8'h90, "pulse");
        step();
        check("pulse_drop_ack", 32'(read_ack), 32'd0);
        check("pulse_hold_data", 32'(read_data), 32'h90);
        for (int i = 0; i < 4; i++) begin
            wr(12'h300 + 12'(i), 8'h40 + 8'(i));
            check("wr_burst_ack", 32'(read_ack), 32'd0);
        end
        rd(12'h302, 8'h42, "wr_burst_rd");

        // Streaming reads over glyph "0".
        read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            read_addr = 12'(i);
            step();
            check("stream_data", 32'(read_data), 32'(stream_exp[i]));
            check("stream_ack", 32'(read_ack), 32'd1);
        end
        read = 1'b0;

        // Same-address collision is read-before-write.
        read = 1'b1; read_addr = 12'h200;
        write = 1'b1; write_addr = 12'h200; write_data = 8'hAA;
        step();
        check("coll_old", 32'(read_data), 32'h00);
        idle();
        rd(12'h200, 8'hAA, "coll_new");

        // Font is writable.
        wr(12'h000, 8'h12);
        rd(12'h000, 8'h12, "font_wr");

        // Reset beats read; same-edge write still lands; array survives.
        rst = 1'b1; read = 1'b1; read_addr = 12'h200;
        write = 1'b1; write_addr = 12'h201; write_data = 8'h55;
        step();
        check("rst_rd_data", 32'(read_data), 32'h00);
        check("rst_rd_ack", 32'(read_ack), 32'd0);
        idle();
        rd(12'h200, 8'hAA, "rst_keep");
        rd(12'h201, 8'h55, "rst_wr");
        rd(12'h000, 8'h12, "rst_keep_font");

        // Full sweep.
        for (int i = 0; i < 4096; i++) begin
            wr(12'(i), 8'(i % 255));
        end
        for (int i = 0; i < 4096; i++) begin
            rd(12'(i), 8'(i % 255), "sweep");
        end
        rd(12'h0FF, 8'h00, "sweep_0FF");
        rd(12'hFFF, 8'h0F, "sweep_FFF");

        // Independent ports at different addresses.
        read = 1'b1; read_addr = 12'h011;
        write = 1'b1; write_addr = 12'h010; write_data = 8'h77;
        step();
        check("indep_rd", 32'(read_data), 32'h11);
        idle();
        rd(12'h010, 8'h77, "indep_wr");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
